// File: rtl/systolic_mv_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_mv_top: weight-stationary 3x4 signed matrix-vector multiply on AXI4-Stream.
// Optional macro SATURATE_EN clamps each result instead of wrapping.   Rev 1.0
// ---------------------------------------------------------------------------
module systolic_mv_top #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int LANES      = 4
) (
  input  logic                        s00_axis_aclk,
  input  logic                        s00_axis_areset,
  input  logic [LANES*DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                        s00_axis_tvalid,
  output logic                        s00_axis_tready,
  input  logic                        s00_axis_tlast,
  output logic [LANES*OUT_WIDTH-1:0]  m00_axis_tdata,
  output logic                        m00_axis_tvalid,
  output logic                        m00_axis_tlast
);

  localparam int ROWS = 3;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int SW   = PW + 2;

  localparam logic [0:0] LOAD_W = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0] state, state_nxt;
  logic [1:0] row_cnt;
  logic       accept, load_en, stream_en;

  logic signed [DATA_WIDTH-1:0] w     [ROWS][LANES];
  logic signed [DATA_WIDTH-1:0] x1    [LANES];
  logic signed [PW-1:0]         prod  [ROWS][LANES];
  logic signed [PW:0]           pair  [ROWS][LANES/2];
  logic signed [SW-1:0]         sum   [ROWS];
  logic        [OUT_WIDTH-1:0]  y     [ROWS];
  logic [3:0]                   vld, lst;

  assign s00_axis_tready = ~s00_axis_areset;
  assign accept          = s00_axis_tvalid & s00_axis_tready;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) state <= LOAD_W;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_W:  if (accept && !s00_axis_tlast && row_cnt == 2'd2) state_nxt = STREAM;
      STREAM:  if (accept && s00_axis_tlast) state_nxt = LOAD_W;
      default: state_nxt = LOAD_W;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    stream_en = 1'b0;
    case (state)
      LOAD_W:  load_en   = accept & ~s00_axis_tlast;
      STREAM:  stream_en = accept;
      default: ;
    endcase
  end

  // A tlast beat during loading aborts the partial load and restarts at row 0.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      row_cnt <= 2'd0;
    end else if (state == LOAD_W && accept) begin
      if (s00_axis_tlast || row_cnt == 2'd2) row_cnt <= 2'd0;
      else                                   row_cnt <= row_cnt + 2'd1;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < LANES; k++) w[r][k] <= '0;
    end else if (load_en) begin
      for (int r = 0; r < ROWS; r++)
        if (int'(row_cnt) == r)
          for (int k = 0; k < LANES; k++)
            w[r][k] <= s00_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Multipliers read w one edge after the vector is captured; a weight beat
  // landing on that same edge is not yet visible, so draining vectors keep
  // the weights that were in effect when they were accepted.
  always_ff @(posedge s00_axis_aclk) begin
    if (stream_en)
      for (int k = 0; k < LANES; k++) x1[k] <= s00_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < LANES; k++)
        prod[r][k] <= PW'(w[r][k]) * PW'(x1[k]);
      for (int j = 0; j < LANES/2; j++)
        pair[r][j] <= (PW+1)'(prod[r][2*j]) + (PW+1)'(prod[r][2*j+1]);
      sum[r] <= SW'(pair[r][0]) + SW'(pair[r][1]);
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      vld <= '0;
      lst <= '0;
    end else begin
      vld <= {vld[2:0], stream_en};
      lst <= {lst[2:0], stream_en & s00_axis_tlast};
    end
  end

`ifdef SATURATE_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      y[r] = sum[r][OUT_WIDTH-1:0];
      if (sum[r] > SAT_MAX)      y[r] = SAT_MAX[OUT_WIDTH-1:0];
      else if (sum[r] < SAT_MIN) y[r] = SAT_MIN[OUT_WIDTH-1:0];
    end
  end
`else
  logic unused_sum_hi;

  always_comb begin
    unused_sum_hi = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      y[r]          = sum[r][OUT_WIDTH-1:0];
      unused_sum_hi = unused_sum_hi ^ (^sum[r][SW-1:OUT_WIDTH]);
    end
  end
`endif

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      m00_axis_tvalid <= vld[3];
      m00_axis_tlast  <= lst[3];
      if (vld[3]) begin
        for (int r = 0; r < ROWS; r++)
          m00_axis_tdata[r*OUT_WIDTH +: OUT_WIDTH] <= y[r];
        for (int r = ROWS; r < LANES; r++)
          m00_axis_tdata[r*OUT_WIDTH +: OUT_WIDTH] <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mv_top.sv
`default_nettype none
// Scoreboard bench for systolic_mv_top: driver feeds a matrix-vector reference
// model that queues expected beats; an independent monitor checks them.
module tb_systolic_mv_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast;

  systolic_mv_top dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    bit          l;
    int          c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: the matrix and where we are in a frame.
  int mw[3][4];
  bit loading;
  int row;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) mw[r][k] = 0;
    loading = 1;
    row     = 0;
  endfunction

  function automatic void model_accept(input logic [63:0] d, input bit last);
    int    x[4];
    exp_t  e;
    logic [15:0] lane;
    for (int k = 0; k < 4; k++) begin
      lane = d[k*16 +: 16];
      x[k] = int'($signed(lane));
    end
    if (loading) begin
      if (last) row = 0;
      else begin
        for (int k = 0; k < 4; k++) mw[row][k] = x[k];
        row++;
        if (row == 3) begin loading = 0; row = 0; end
      end
    end else begin
      e.d = 64'd0;
      for (int r = 0; r < 3; r++) begin
        longint s = 0;
        logic [63:0] sv;
        for (int k = 0; k < 4; k++) s += longint'(mw[r][k]) * longint'(x[k]);
`ifdef SATURATE_EN
        if (s > 32767)       s = 32767;
        else if (s < -32768) s = -32768;
`endif
        sv = s;
        e.d[r*16 +: 16] = sv[15:0];
      end
      e.l = last;
      e.c = cyc;
      q.push_back(e);
      if (last) loading = 1;
    end
  endfunction

  task automatic drive(input logic [63:0] d, input bit last, input bit valid);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = valid;
    @(posedge clk);
    #1;
    if (valid && !rst) model_accept(d, last);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
    logic [15:0] l0, l1, l2, l3;
    l0 = a[15:0]; l1 = b[15:0]; l2 = c[15:0]; l3 = d[15:0];
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [15:0] rnd_lane();
    case ($urandom_range(0, 5))
      0:       return 16'h7fff;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rnd_beat();
    return {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every output beat must match the oldest queued expectation,
  // exactly four cycles after its vector was accepted.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %h last %0b with nothing expected", m_tdata, m_tlast);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (m_tdata !== e.d || m_tlast !== e.l || cyc != e.c + 4) begin
            errors++;
            $display("FAIL out_beat: got data %h last %0b cycle %0d expected data %h last %0b cycle %0d",
                     m_tdata, m_tlast, cyc, e.d, e.l, e.c + 4);
          end
        end
      end else begin
        checks++;
        if (m_tlast !== 1'b0) begin
          errors++;
          $display("FAIL idle_tlast: got %0b expected 0", m_tlast);
        end
      end
    end
  end

  task automatic load3(input logic [63:0] r0, input logic [63:0] r1, input logic [63:0] r2);
    drive(r0, 0, 1);
    drive(r1, 0, 1);
    drive(r2, 0, 1);
  endtask

  task automatic base_frame();
    load3(pack(0, 1, 2, 3), pack(4, 5, 6, 7), pack(8, 9, 10, 11));
    for (int i = 0; i < 12; i++) drive(pack(4*i, 4*i+1, 4*i+2, 4*i+3), i == 11, 1);
  endtask

  initial begin
    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tready", 64'(s_tready), 64'd0);
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_tlast",  64'(m_tlast),  64'd0);
    check("reset_tdata",  m_tdata,       64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(s_tready), 64'd1);

    // Single vector, then a 12-vector frame on the same weights.
    load3(pack(0, 1, 2, 3), pack(4, 5, 6, 7), pack(8, 9, 10, 11));
    drive(pack(0, 1, 2, 3), 0, 1);
    repeat (6) drive(64'd0, 0, 0);
    check("single_vector_result", q.size() == 0 ? m_tdata : 64'hx, 64'h0000_003e_0026_000e);
    for (int i = 0; i < 12; i++) drive(pack(4*i, 4*i+1, 4*i+2, 4*i+3), i == 11, 1);
    repeat (6) drive(64'd0, 0, 0);
    check("frame_last_result", m_tdata, 64'h0000_06c6_03ee_0116);

    // Same frame again after idling: the FSM must be back in LOAD_W.
    repeat (30) drive(64'($urandom), 0, 0);
    base_frame();

    // Overflow of row 0.
    load3(pack(32'h7fff, 32'h7fff, 32'h7fff, 32'h7fff), rnd_beat(), rnd_beat());
    drive(pack(32'h7fff, 32'h7fff, 32'h7fff, 32'h7fff), 1, 1);

    // tlast on the second weight beat aborts the load; next three beats reload.
    drive(rnd_beat(), 0, 1);
    drive(rnd_beat(), 1, 1);
    repeat (6) drive(64'd0, 0, 0);
    load3(rnd_beat(), rnd_beat(), rnd_beat());
    for (int i = 0; i < 5; i++) drive(rnd_beat(), i == 4, 1);

    // Randomized frames with gaps, aborted loads and back-to-back reloads.
    for (int f = 0; f < 25; f++) begin
      int nv;
      while (loading) drive(rnd_beat(), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      nv = $urandom_range(1, 10);
      for (int i = 0; i < nv; i++) begin
        if ($urandom_range(0, 3) == 0) drive(rnd_beat(), 1, 0);
        drive(rnd_beat(), i == nv - 1, 1);
      end
    end

    // Reset in the middle of a frame drops everything in flight.
    load3(rnd_beat(), rnd_beat(), rnd_beat());
    for (int i = 0; i < 3; i++) drive(rnd_beat(), 0, 1);
    rst = 1'b1;
    drive(rnd_beat(), 0, 1);
    q.delete();
    model_reset();
    check("tready_in_reset", 64'(s_tready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(64'd0, 0, 0);
      check("no_output_after_reset", 64'(m_tvalid), 64'd0);
    end
    base_frame();

    begin
      int guard = 0;
      while (q.size() != 0 && guard < 20) begin
        drive(64'd0, 0, 0);
        guard++;
      end
    end
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    repeat (3) drive(64'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
